// File: rtl/cdc_pkg.sv
// Shared constants and elaboration helpers for clock-domain-crossing blocks.
package cdc_pkg;

  localparam int DEFAULT_SYNC_STAGES = 2;

  // Fewer than two flops gives no meaningful metastability settling time.
  function automatic bit sync_stages_ok(input int stages);
    return stages >= 2;
  endfunction

endpackage

// File: rtl/mux_en_sync_if.sv
// Source/destination bundle for the mux-enable synchronizer: request, data bus, and returned status.
interface mux_en_sync_if #(
  parameter int WIDTH = 8
);

  logic             en_in;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             en_ack;

  modport master (
    output en_in,
    output data_in,
    input  data_out,
    input  data_valid,
    input  en_ack
  );

  modport slave (
    input  en_in,
    input  data_in,
    output data_out,
    output data_valid,
    output en_ack
  );

endinterface

// File: rtl/mux_en_sync_sync_bit.sv
// Generic single-bit N-flop synchronizer with a synchronous active-high reset.
module sync_bit
  import cdc_pkg::*;
#(
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  if (!sync_stages_ok(SYNC_STAGES)) begin : g_bad_stages
    $error("sync_bit: SYNC_STAGES must be at least 2");
  end

  (* ASYNC_REG = "TRUE", dont_touch = "true" *)
  logic [SYNC_STAGES-1:0] s;

  always_ff @(posedge clk) begin
    if (rst) begin
      s <= '0;
    end else begin
      s <= {s[SYNC_STAGES-2:0], d};
    end
  end

  assign q = s[SYNC_STAGES-1];

endmodule

// File: rtl/mux_en_sync.sv
// Destination half of a mux-enable CDC: synchronizes en_in and loads data_in on its synchronized rising edge.
module mux_en_sync
  import cdc_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic          clk,
  input  logic          rst,
  mux_en_sync_if.slave  bus
);

  if (!sync_stages_ok(SYNC_STAGES)) begin : g_bad_stages
    $error("mux_en_sync: SYNC_STAGES must be at least 2");
  end

  logic             en_sync;
  logic             s_prev;
  logic             load;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;

  sync_bit #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_en (
    .clk (clk),
    .rst (rst),
    .d   (bus.en_in),
    .q   (en_sync)
  );

  assign load = en_sync & ~s_prev;

  // data_in is only trusted on the load edge; the source holds it stable until en_ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_prev  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      s_prev  <= en_sync;
      valid_q <= load;
      if (load) begin
        data_q <= bus.data_in;
      end
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.en_ack     = en_sync;

endmodule

// File: tb/tb_mux_en_sync.sv
// Self-checking bench for mux_en_sync: directed scenarios plus randomized traffic against a delay-line model.
module tb_mux_en_sync;

  localparam int WIDTH = 8;
  localparam int S     = 2;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mux_en_sync_if #(.WIDTH(WIDTH)) bus ();

  mux_en_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (S)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the destination sees en_in delayed by S edges; a capture happens
  // on the first edge at which that delayed view turns from 0 to 1.
  bit               hist[$];
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ack;

  function automatic bit delayed_en(input int back);
    int idx;
    idx = hist.size() - S - back;
    return (idx >= 0) ? hist[idx] : 1'b0;
  endfunction

  task automatic step(input logic r, input logic e, input logic [WIDTH-1:0] d);
    bit seen_now;
    bit seen_before;
    @(negedge clk);
    rst         = r;
    bus.en_in   = e;
    bus.data_in = d;
    @(posedge clk);
    if (r) begin
      hist.delete();
      m_data  = '0;
      m_valid = 1'b0;
    end else begin
      seen_now    = delayed_en(0);
      seen_before = delayed_en(1);
      m_valid     = seen_now && !seen_before;
      if (m_valid) m_data = d;
      hist.push_back(e);
    end
    m_ack = delayed_en(0);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 8'hFF);
      checks++;
      if (bus.data_out !== 8'h00) begin
        errors++; $display("FAIL reset_data cyc %0d got %h want 00", i, bus.data_out);
      end
      checks++;
      if (bus.data_valid !== 1'b0) begin
        errors++; $display("FAIL reset_valid cyc %0d got %b want 0", i, bus.data_valid);
      end
      checks++;
      if (bus.en_ack !== 1'b0) begin
        errors++; $display("FAIL reset_ack cyc %0d got %b want 0", i, bus.en_ack);
      end
    end
    step(1'b0, 1'b0, 8'hFF);
  endtask

  task automatic test_basic();
    logic       exp_ack[4]   = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic       exp_valid[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] exp_data[4]  = '{8'h00, 8'h00, 8'h06, 8'h06};
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 8'h06);
      checks++;
      if (bus.en_ack !== exp_ack[i]) begin
        errors++; $display("FAIL basic_ack k+%0d got %b want %b", i, bus.en_ack, exp_ack[i]);
      end
      checks++;
      if (bus.data_valid !== exp_valid[i]) begin
        errors++; $display("FAIL basic_valid k+%0d got %b want %b", i, bus.data_valid, exp_valid[i]);
      end
      checks++;
      if (bus.data_out !== exp_data[i]) begin
        errors++; $display("FAIL basic_data k+%0d got %h want %h", i, bus.data_out, exp_data[i]);
      end
    end
  endtask

  task automatic test_second();
    int pulses;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 8'h06);
      if (bus.data_valid === 1'b1) pulses++;
    end
    checks++;
    if (bus.data_out !== 8'h06) begin
      errors++; $display("FAIL second_before got %h want 06", bus.data_out);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 8'h01);
      if (bus.data_valid === 1'b1) pulses++;
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 8'h01);
      if (bus.data_valid === 1'b1) pulses++;
    end
    checks++;
    if (bus.data_out !== 8'h01) begin
      errors++; $display("FAIL second_data got %h want 01", bus.data_out);
    end
    checks++;
    if (pulses != 1) begin
      errors++; $display("FAIL second_pulses got %0d want 1", pulses);
    end
  endtask

  task automatic test_idle_toggle();
    logic [7:0] d;
    for (int i = 0; i < 8; i++) begin
      d = (i % 2 == 0) ? 8'hAA : 8'h55;
      step(1'b0, 1'b0, d);
      checks++;
      if (bus.data_out !== 8'h01 || bus.data_valid !== 1'b0) begin
        errors++;
        $display("FAIL idle cyc %0d got data %h valid %b want data 01 valid 0",
                 i, bus.data_out, bus.data_valid);
      end
    end
  endtask

  task automatic test_held();
    int pulses;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 8'h3C);
      if (bus.data_valid === 1'b1) pulses++;
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 8'h3C);
      if (bus.data_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1) begin
      errors++; $display("FAIL held_pulses got %0d want 1", pulses);
    end
    checks++;
    if (bus.data_out !== 8'h3C) begin
      errors++; $display("FAIL held_data got %h want 3C", bus.data_out);
    end
  endtask

  task automatic test_reset_mid();
    logic       exp_valid[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] exp_data[4]  = '{8'h00, 8'h00, 8'h77, 8'h77};
    step(1'b0, 1'b1, 8'h77);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 8'h77);
      checks++;
      if (bus.data_out !== 8'h00 || bus.data_valid !== 1'b0 || bus.en_ack !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_clear cyc %0d got data %h valid %b ack %b want 00 0 0",
                 i, bus.data_out, bus.data_valid, bus.en_ack);
      end
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 8'h77);
      checks++;
      if (bus.data_valid !== exp_valid[i] || bus.data_out !== exp_data[i]) begin
        errors++;
        $display("FAIL rstmid_reload e%0d got data %h valid %b want %h %b",
                 i + 1, bus.data_out, bus.data_valid, exp_data[i], exp_valid[i]);
      end
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_random();
    logic             e;
    logic             r;
    logic [WIDTH-1:0] d;
    int               hold;
    e    = 1'b0;
    d    = 8'h00;
    hold = 0;
    for (int i = 0; i < 400; i++) begin
      if (hold == 0) begin
        e = ~e;
        // Mostly contract-respecting lengths, sometimes short pulses that may be lost.
        hold = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 2) : $urandom_range(3, 8);
        if (e) d = WIDTH'($urandom);
      end
      hold--;
      if ($urandom_range(0, 9) == 0) d = WIDTH'($urandom);
      r = ($urandom_range(0, 59) == 0);
      step(r, e, d);
      checks++;
      if (bus.data_out !== m_data || bus.data_valid !== m_valid || bus.en_ack !== m_ack) begin
        errors++;
        $display("FAIL random cyc %0d got data %h valid %b ack %b want %h %b %b",
                 i, bus.data_out, bus.data_valid, bus.en_ack, m_data, m_valid, m_ack);
      end
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    bus.en_in   = 1'b0;
    bus.data_in = '0;
    m_data      = '0;
    m_valid     = 1'b0;
    m_ack       = 1'b0;
    test_reset();
    test_basic();
    test_second();
    test_idle_toggle();
    test_held();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
